// File: rtl/conv_accumulator_pkg.sv
// Shared types and constants for the channel-accumulation stage.
package conv_accumulator_pkg;

  localparam int SIZE_W = 11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/conv_accumulator_acc_lane.sv
// One accumulation lane: product plus bias (first pass) or stored partial sum.
module acc_lane #(
  parameter int DW = 22
) (
  input  logic [DW-1:0] data,
  input  logic [DW-1:0] bias,
  input  logic [DW-1:0] psum,
  input  logic          first,
  output logic [DW-1:0] sum
);

  // Two's complement wrap: the carry out of the top bit is simply dropped.
  assign sum = data + (first ? bias : psum);

endmodule

// File: rtl/conv_accumulator.sv
// Channel accumulator: issues bias/partial-sum RAM reads one cycle ahead of each
// beat, adds them to the streamed products and writes back or emits the result.
module conv_accumulator
  import conv_accumulator_pkg::*;
#(
  parameter int AW  = 8,
  parameter int DW  = 22,
  parameter int DN  = 1,
  parameter int CW1 = 28,
  parameter int CW2 = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fc,
  input  logic [AW-1:0]     base,
  input  logic [SIZE_W-1:0] size,
  input  logic              m_valid1_pre,
  input  logic              m_valid1,
  input  logic [DW*DN-1:0]  m_data1,
  input  logic              m_first,
  input  logic              m_last,
  input  logic [CW1-1:0]    m_ctrl,
  input  logic [DW*DN-1:0]  m_data2,
  input  logic [DW*DN-1:0]  m_data3,
  output logic              m_ready,
  output logic [AW-1:0]     m_addr2,
  output logic [AW-1:0]     m_addr3,
  output logic [AW-1:0]     m_w_addr,
  output logic [DW*DN-1:0]  m_sum,
  output logic              m_valid,
  output logic [DW*DN-1:0]  s_sum,
  output logic              s_valid,
  output logic              s_first,
  output logic              s_last,
  output logic [CW2-1:0]    s_ctrl,
  output state_e            dbg_state
);

  state_e              state, state_nxt;
  logic [AW-1:0]       base_q;
  logic [SIZE_W-1:0]   size_q;
  logic                fc_q;
  logic [SIZE_W-1:0]   idx;
  logic [SIZE_W-1:0]   pipe_idx;
  logic [DW*DN-1:0]    sum_c;
  logic                start_ok;
  logic                beat_ok;
  logic                job_done;
  logic                unused_ctrl;

  // Handshake: m_ready is high for the whole RUN state and never deasserts
  // mid-job; every m_valid1_pre/m_valid1 seen while m_ready=1 is consumed.
  assign m_ready   = (state == RUN);
  assign dbg_state = state;

  assign start_ok = start && (size != '0);
  assign beat_ok  = m_valid1 && (state == RUN);
  assign job_done = beat_ok && m_last && (pipe_idx == size_q - SIZE_W'(1));

  assign unused_ctrl = ^m_ctrl[CW1-1:CW2];

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = RUN;
      RUN:  if (!start_ok && job_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < DN; g++) begin : g_lane
    acc_lane #(.DW(DW)) u_lane (
      .data  (m_data1[g*DW +: DW]),
      .bias  (m_data2[g*DW +: DW]),
      .psum  (m_data3[g*DW +: DW]),
      .first (m_first),
      .sum   (sum_c[g*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      base_q   <= '0;
      size_q   <= '0;
      fc_q     <= 1'b0;
      idx      <= '0;
      pipe_idx <= '0;
      m_addr2  <= '0;
      m_addr3  <= '0;
      m_w_addr <= '0;
      m_sum    <= '0;
      m_valid  <= 1'b0;
      s_sum    <= '0;
      s_valid  <= 1'b0;
      s_first  <= 1'b0;
      s_last   <= 1'b0;
      s_ctrl   <= '0;
    end else begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      s_first <= 1'b0;
      s_last  <= 1'b0;

      // A restart wins over an address request in the same cycle.
      if (start_ok) begin
        base_q <= base;
        size_q <= size;
        fc_q   <= fc;
        idx    <= '0;
      end else if (m_valid1_pre && state == RUN) begin
        m_addr3  <= base_q + AW'(idx);
        m_addr2  <= fc_q ? base_q + AW'(idx) : base_q;
        pipe_idx <= idx;
        idx      <= (idx == size_q - SIZE_W'(1)) ? '0 : idx + SIZE_W'(1);
      end

      if (beat_ok) begin
        if (m_last) begin
          s_valid <= 1'b1;
          s_sum   <= sum_c;
          s_ctrl  <= m_ctrl[CW2-1:0];
          s_first <= (pipe_idx == '0);
          s_last  <= (pipe_idx == size_q - SIZE_W'(1));
        end else begin
          m_valid  <= 1'b1;
          m_sum    <= sum_c;
          m_w_addr <= base_q + AW'(pipe_idx);
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_accumulator.sv
// Bench for conv_accumulator: directed and random jobs against a queue-based
// reference model, with a monitor that checks addresses, write-backs and results.
module tb_conv_accumulator;
  import conv_accumulator_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 22;
  localparam int DN  = 1;
  localparam int CW1 = 28;
  localparam int CW2 = 24;
  localparam int LW  = DW * DN;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              fc;
  logic [AW-1:0]     base;
  logic [SIZE_W-1:0] size;
  logic              m_valid1_pre;
  logic              m_valid1;
  logic [LW-1:0]     m_data1;
  logic              m_first;
  logic              m_last;
  logic [CW1-1:0]    m_ctrl;
  logic [LW-1:0]     m_data2;
  logic [LW-1:0]     m_data3;
  logic              m_ready;
  logic [AW-1:0]     m_addr2;
  logic [AW-1:0]     m_addr3;
  logic [AW-1:0]     m_w_addr;
  logic [LW-1:0]     m_sum;
  logic              m_valid;
  logic [LW-1:0]     s_sum;
  logic              s_valid;
  logic              s_first;
  logic              s_last;
  logic [CW2-1:0]    s_ctrl;
  state_e            dbg_state;

  conv_accumulator #(.AW(AW), .DW(DW), .DN(DN), .CW1(CW1), .CW2(CW2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .fc           (fc),
    .base         (base),
    .size         (size),
    .m_valid1_pre (m_valid1_pre),
    .m_valid1     (m_valid1),
    .m_data1      (m_data1),
    .m_first      (m_first),
    .m_last       (m_last),
    .m_ctrl       (m_ctrl),
    .m_data2      (m_data2),
    .m_data3      (m_data3),
    .m_ready      (m_ready),
    .m_addr2      (m_addr2),
    .m_addr3      (m_addr3),
    .m_w_addr     (m_w_addr),
    .m_sum        (m_sum),
    .m_valid      (m_valid),
    .s_sum        (s_sum),
    .s_valid      (s_valid),
    .s_first      (s_first),
    .s_last       (s_last),
    .s_ctrl       (s_ctrl),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters and check helpers
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  // ---------------- external RAMs (environment, not reference)
  logic [LW-1:0] bias_ram [256];
  logic [LW-1:0] psum_ram [256];

  function automatic logic [LW-1:0] init_psum(input int a);
    return LW'(a * 1237 + 17);
  endfunction

  assign m_data2 = bias_ram[m_addr2];
  assign m_data3 = psum_ram[m_addr3];

  // ---------------- reference model state and scoreboard queues
  logic [LW-1:0]        mdl_psum [256];
  logic [AW-1:0]        mdl_base;
  int                   mdl_size;
  logic                 mdl_fc;
  logic                 mdl_run;
  int                   mdl_e;
  logic [LW-1:0]        pdata [32];

  logic [2*AW-1:0]      addr_q [$];
  logic [AW+LW-1:0]     wb_q [$];
  logic [LW+2+CW2-1:0]  out_q [$];

  // ---------------- monitor: pops expectations whenever the DUT presents them
  initial begin
    logic [2*AW-1:0]     ea;
    logic [AW+LW-1:0]    ew;
    logic [LW+2+CW2-1:0] eo;
    for (int a = 0; a < 256; a++) psum_ram[a] = init_psum(a);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (m_valid1 && m_ready) begin
          if (addr_q.size() == 0) flag("addr_unexpected");
          else begin
            ea = addr_q.pop_front();
            check("m_addr3", 64'(m_addr3), 64'(ea[2*AW-1:AW]));
            check("m_addr2", 64'(m_addr2), 64'(ea[AW-1:0]));
          end
        end
        if (m_valid) begin
          if (wb_q.size() == 0) flag("wb_unexpected");
          else begin
            ew = wb_q.pop_front();
            check("m_w_addr", 64'(m_w_addr), 64'(ew[AW+LW-1:LW]));
            check("m_sum", 64'(m_sum), 64'(ew[LW-1:0]));
          end
          psum_ram[m_w_addr] = m_sum;
        end
        if (s_valid) begin
          if (out_q.size() == 0) flag("out_unexpected");
          else begin
            eo = out_q.pop_front();
            check("s_sum", 64'(s_sum), 64'(eo[LW+2+CW2-1:2+CW2]));
            check("s_first", 64'(s_first), 64'(eo[CW2+1]));
            check("s_last", 64'(s_last), 64'(eo[CW2]));
            check("s_ctrl", 64'(s_ctrl), 64'(eo[CW2-1:0]));
          end
        end
      end
    end
  end

  // ---------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input int s, input logic f);
    start = 1'b1;
    base  = b;
    size  = SIZE_W'(s);
    fc    = f;
    tick();
    start = 1'b0;
    if (s != 0) begin
      mdl_base = b;
      mdl_size = s;
      mdl_fc   = f;
      mdl_run  = 1'b1;
      mdl_e    = 0;
    end
  endtask

  // Reference behaviour of one announced beat: element mdl_e of the current pass.
  task automatic model_beat(input int i, input logic f, input logic l, input logic [CW1-1:0] ctrl);
    logic [AW-1:0] addr;
    logic [AW-1:0] a2;
    logic [LW-1:0] sum;
    addr = mdl_base + AW'(mdl_e);
    a2   = mdl_fc ? addr : mdl_base;
    addr_q.push_back({addr, a2});
    sum = pdata[i] + (f ? bias_ram[a2] : mdl_psum[addr]);
    if (l) begin
      out_q.push_back({sum, (mdl_e == 0), (mdl_e == mdl_size - 1), ctrl[CW2-1:0]});
      if (mdl_e == mdl_size - 1) mdl_run = 1'b0;
    end else begin
      mdl_psum[addr] = sum;
      wb_q.push_back({addr, sum});
    end
    mdl_e = (mdl_e == mdl_size - 1) ? 0 : mdl_e + 1;
  endtask

  task automatic drive_pass(input logic f, input logic l, input int n, input logic [CW1-1:0] ctrl);
    for (int i = 0; i <= n; i++) begin
      m_valid1_pre = (i < n);
      if (i < n && mdl_run) model_beat(i, f, l, ctrl);
      m_valid1 = (i > 0);
      m_data1  = (i > 0) ? pdata[i-1] : '0;
      m_first  = f;
      m_last   = l;
      m_ctrl   = ctrl;
      tick();
    end
    m_valid1_pre = 1'b0;
    m_valid1     = 1'b0;
    m_first      = 1'b0;
    m_last       = 1'b0;
    m_data1      = '0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (addr_q.size() + wb_q.size() + out_q.size()) != 0; k++) tick();
    if ((addr_q.size() + wb_q.size() + out_q.size()) != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", addr_q.size() + wb_q.size() + out_q.size());
      addr_q.delete();
      wb_q.delete();
      out_q.delete();
    end
    tick();
    tick();
  endtask

  // ---------------- main sequence
  initial begin
    int b, s, np;
    logic f;
    rst_n = 1'b1;
    start = 1'b0;
    fc = 1'b0;
    base = '0;
    size = '0;
    m_valid1_pre = 1'b0;
    m_valid1 = 1'b0;
    m_data1 = '0;
    m_first = 1'b0;
    m_last = 1'b0;
    m_ctrl = '0;
    mdl_run = 1'b0;
    mdl_e = 0;
    mdl_base = '0;
    mdl_size = 0;
    mdl_fc = 1'b0;
    for (int a = 0; a < 256; a++) begin
      mdl_psum[a] = init_psum(a);
      bias_ram[a] = LW'($urandom);
    end

    // Reset values
    tick();
    tick();
    check("rst_m_ready", 64'(m_ready), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_s_valid", 64'(s_valid), 64'd0);
    check("rst_outputs", {m_addr2, m_addr3, m_w_addr, s_first, s_last}, 64'd0);
    check("rst_sums", {m_sum, s_sum}, 64'd0);
    check("rst_s_ctrl", 64'(s_ctrl), 64'd0);
    rst_n = 1'b0;
    tick();

    do_start(8'd0, 4, 1'b0);
    check("ready_after_start", 64'(m_ready), 64'd1);

    // Three-pass conv job, restarted from RUN
    bias_ram[8] = LW'(100);
    do_start(8'd8, 4, 1'b0);
    for (int i = 0; i < 4; i++) pdata[i] = LW'(i + 1);
    drive_pass(1'b1, 1'b0, 4, '0);
    drain();
    for (int i = 0; i < 4; i++) pdata[i] = LW'(10);
    drive_pass(1'b0, 1'b0, 4, '0);
    drain();
    for (int i = 0; i < 4; i++) pdata[i] = LW'(1);
    drive_pass(1'b0, 1'b1, 4, 28'h1234567);
    drain();
    check("idle_after_job", 64'(m_ready), 64'd0);

    // size=0 start is ignored
    do_start(8'd3, 0, 1'b0);
    check("size0_ignored", 64'(m_ready), 64'd0);

    // fc mode single pass
    bias_ram[0] = LW'(5);
    bias_ram[1] = LW'(6);
    bias_ram[2] = LW'(7);
    do_start(8'd0, 3, 1'b1);
    for (int i = 0; i < 3; i++) pdata[i] = LW'(1);
    drive_pass(1'b1, 1'b1, 3, 28'h0000042);
    drain();
    check("idle_after_fc", 64'(m_ready), 64'd0);

    // Address wrap and signed overflow
    bias_ram[254] = LW'(1);
    do_start(8'd254, 4, 1'b0);
    pdata[0] = 22'h1FFFFF;
    for (int i = 1; i < 4; i++) pdata[i] = LW'($urandom);
    drive_pass(1'b1, 1'b1, 4, 28'h0000001);
    drain();

    // Restart mid-pass
    do_start(8'd100, 4, 1'b0);
    pdata[0] = LW'(7);
    pdata[1] = LW'(9);
    drive_pass(1'b1, 1'b0, 2, '0);
    drain();
    do_start(8'd40, 4, 1'b0);
    check("ready_after_restart", 64'(m_ready), 64'd1);
    for (int i = 0; i < 4; i++) pdata[i] = LW'($urandom);
    drive_pass(1'b1, 1'b1, 4, 28'hABCDEF1);
    drain();
    check("idle_after_restart_job", 64'(m_ready), 64'd0);

    // Reset mid-job
    do_start(8'd16, 5, 1'b0);
    check("ready_before_reset", 64'(m_ready), 64'd1);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    mdl_run = 1'b0;
    check("ready_after_reset", 64'(m_ready), 64'd0);
    check("state_after_reset", 64'(dbg_state), 64'(IDLE));
    tick();

    // Random jobs
    for (int j = 0; j < 8; j++) begin
      b  = $urandom_range(0, 255);
      s  = $urandom_range(3, 10);
      f  = 1'($urandom_range(0, 1));
      np = $urandom_range(1, 3);
      do_start(AW'(b), s, f);
      for (int p = 0; p < np; p++) begin
        for (int i = 0; i < s; i++) pdata[i] = LW'($urandom);
        drive_pass(p == 0, p == np - 1, s, CW1'($urandom));
        drain();
      end
      check("idle_after_random", 64'(m_ready), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
